// File: rtl/jzjpcc_pkg.sv
// Shared types and constants for the jzjpcc SRAM arbiter and its burst limiter.
// Owner encoding and the counter-width helper live here so both files agree.
package jzjpcc_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  // addi x0,x0,0 with the always-11 low bits stripped, as decode sees it
  localparam logic [29:0] NOP_INSTR = 30'(32'h0000_0013 >> 2);

  localparam int unsigned MAX_DATA_BURST_DEF = 4;

  function automatic int unsigned burst_cnt_w(input int unsigned max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

  localparam int unsigned BURST_CNT_W_DEF = burst_cnt_w(MAX_DATA_BURST_DEF);

endpackage

// File: rtl/jzjpcc_burst_limiter.sv
// Saturating count of consecutive data grants; allow drops once the limit is
// reached so the arbiter hands fetch exactly one cycle before data resumes.
module jzjpcc_burst_limiter
  import jzjpcc_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_DATA_BURST_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic allow_o
);

  localparam int unsigned CW = burst_cnt_w(MAX_BURST);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_BURST);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign allow_o = (cnt_q < MAX_C);

endmodule

// File: rtl/jzjpcc_mem_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and the memory stage.
// Data has priority up to a bounded burst; fetch is stalled/flushed around it.
module jzjpcc_mem_arbiter
  import jzjpcc_pkg::*;
#(
  parameter int unsigned PC_MAX_B       = 15,
  parameter int unsigned MAX_DATA_BURST = MAX_DATA_BURST_DEF
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,

  input  logic [PC_MAX_B:2]     fetch_addr_i,
  output logic                  fetch_stall_o,
  output logic                  fetch_flush_o,
  output logic [31:2]           fetch_instr_o,

  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [PC_MAX_B:2]     data_addr_i,
  input  logic [3:0]            data_byteen_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,

  output logic [PC_MAX_B:2]     ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_byteen_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  owner_t owner_q, owner_d;
  logic   burst_allow;
  logic   data_gnt;

  jzjpcc_burst_limiter #(
    .MAX_BURST (MAX_DATA_BURST)
  ) u_burst (
    .clk_i   (clock_i),
    .rst_ni  (reset_ni),
    .inc_i   (data_gnt),
    .clr_i   (!data_gnt),
    .allow_o (burst_allow)
  );

  // Reset gates the grant combinationally so nothing is written while held.
  assign data_gnt = data_req_i & burst_allow & reset_ni;

  always_comb begin
    owner_d      = OWN_FETCH;
    ram_addr_o   = fetch_addr_i;
    ram_we_o     = 1'b0;
    ram_byteen_o = 4'b0000;
    ram_wdata_o  = '0;
    if (data_gnt) begin
      owner_d      = OWN_DATA;
      ram_addr_o   = data_addr_i;
      ram_we_o     = data_we_i;
      ram_byteen_o = data_byteen_i;
      ram_wdata_o  = data_wdata_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign data_gnt_o    = data_gnt;
  assign fetch_stall_o = data_gnt | !reset_ni;
  assign fetch_flush_o = (owner_q != OWN_FETCH);
  assign data_rvalid_o = (owner_q == OWN_DATA);
  assign data_rdata_o  = ram_rdata_i;
  assign fetch_instr_o = ram_rdata_i[31:2];

endmodule

// File: tb/tb_jzjpcc_mem_arbiter.sv
// Directed bench: arbiter (burst 4) with a behavioural SRAM, plus a burst-1
// instance to check strict alternation.
module tb_jzjpcc_mem_arbiter;

  logic        clock;
  logic        reset_n;
  logic [15:2] fetch_addr;
  logic        data_req, data_we;
  logic [15:2] data_addr;
  logic [3:0]  data_byteen;
  logic [31:0] data_wdata;
  logic        fetch_stall, fetch_flush, data_gnt, data_rvalid;
  logic [31:2] fetch_instr;
  logic [31:0] data_rdata;
  logic [15:2] ram_addr;
  logic        ram_we;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_wdata, ram_rdata;

  logic        data_req1;
  logic        fetch_stall1, fetch_flush1, data_gnt1, data_rvalid1;
  logic [31:2] fetch_instr1;
  logic [31:0] data_rdata1;
  logic [15:2] ram_addr1;
  logic        ram_we1;
  logic [3:0]  ram_byteen1;
  logic [31:0] ram_wdata1;
  logic [31:0] ram_rdata1;

  logic [31:0] mem [0:16383];
  int checks = 0;
  int errors = 0;

  jzjpcc_mem_arbiter #(.PC_MAX_B(15), .MAX_DATA_BURST(4)) dut (
    .clock_i(clock), .reset_ni(reset_n),
    .fetch_addr_i(fetch_addr), .fetch_stall_o(fetch_stall),
    .fetch_flush_o(fetch_flush), .fetch_instr_o(fetch_instr),
    .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
    .data_byteen_i(data_byteen), .data_wdata_i(data_wdata),
    .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_byteen_o(ram_byteen),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  jzjpcc_mem_arbiter #(.PC_MAX_B(15), .MAX_DATA_BURST(1)) dut1 (
    .clock_i(clock), .reset_ni(reset_n),
    .fetch_addr_i(fetch_addr), .fetch_stall_o(fetch_stall1),
    .fetch_flush_o(fetch_flush1), .fetch_instr_o(fetch_instr1),
    .data_req_i(data_req1), .data_we_i(1'b0), .data_addr_i(14'h0004),
    .data_byteen_i(4'b0000), .data_wdata_i(32'h0),
    .data_gnt_o(data_gnt1), .data_rvalid_o(data_rvalid1), .data_rdata_o(data_rdata1),
    .ram_addr_o(ram_addr1), .ram_we_o(ram_we1), .ram_byteen_o(ram_byteen1),
    .ram_wdata_o(ram_wdata1), .ram_rdata_i(ram_rdata1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered-address SRAM: read returns pre-write contents one cycle later.
  always @(posedge clock) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] w;
  logic [11:0] pat;

  initial begin
    ram_rdata1  = 32'h0;
    reset_n     = 1'b0;
    data_req    = 1'b1;
    data_we     = 1'b1;
    data_addr   = 14'h0004;
    data_byteen = 4'hF;
    data_wdata  = 32'h0;
    data_req1   = 1'b0;
    fetch_addr  = 14'h0040;
    mem[14'h0004] = 32'h1234_5678;
    mem[14'h0008] = 32'h1122_3344;
    mem[14'h0040] = 32'hCAFE_F00D;

    // Held in reset with a store request pending: nothing may be granted.
    repeat (2) @(negedge clock);
    chk("rst_gnt",    data_gnt,    0);
    chk("rst_we",     ram_we,      0);
    chk("rst_stall",  fetch_stall, 1);
    chk("rst_flush",  fetch_flush, 1);
    chk("rst_rvalid", data_rvalid, 0);
    chk("rst_flush1", fetch_flush1, 1);
    data_req = 1'b0;
    data_we  = 1'b0;

    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("rel_flush", fetch_flush, 1);
    chk("rel_addr",  ram_addr,    32'h40);
    chk("rel_stall", fetch_stall, 0);
    cyc();
    @(negedge clock);
    w = 32'hCAFE_F00D;
    chk("rel2_flush", fetch_flush, 0);
    chk("rel2_instr", fetch_instr, {2'b00, w[31:2]});

    // Single load from word 0x4
    cyc();
    data_req = 1'b1; data_we = 1'b0; data_addr = 14'h0004;
    @(negedge clock);
    chk("ld_gnt",   data_gnt,    1);
    chk("ld_stall", fetch_stall, 1);
    chk("ld_addr",  ram_addr,    32'h4);
    chk("ld_we",    ram_we,      0);
    cyc();
    data_req = 1'b0;
    @(negedge clock);
    chk("ld_rvalid", data_rvalid, 1);
    chk("ld_flush",  fetch_flush, 1);
    chk("ld_rdata",  data_rdata,  32'h1234_5678);
    chk("ld_refetch_addr", ram_addr, 32'h40);
    cyc();
    @(negedge clock);
    chk("ld_after_rvalid", data_rvalid, 0);
    chk("ld_after_flush",  fetch_flush, 0);

    // Half-word store to 0x8, then read back
    cyc();
    data_req = 1'b1; data_we = 1'b1; data_addr = 14'h0008;
    data_byteen = 4'b0011; data_wdata = 32'hDEAD_BEEF;
    @(negedge clock);
    chk("st_gnt",    data_gnt,   1);
    chk("st_we",     ram_we,     1);
    chk("st_byteen", ram_byteen, 32'h3);
    chk("st_wdata",  ram_wdata,  32'hDEAD_BEEF);
    cyc();
    data_req = 1'b0; data_we = 1'b0;
    @(negedge clock);
    chk("st_rvalid", data_rvalid, 1);
    chk("st_fetch_we", ram_we, 0);
    cyc();
    data_req = 1'b1; data_addr = 14'h0008;
    @(negedge clock);
    chk("rb_gnt", data_gnt, 1);
    cyc();
    data_req = 1'b0;
    @(negedge clock);
    chk("rb_rvalid", data_rvalid, 1);
    chk("rb_low",    {16'h0, data_rdata[15:0]}, 32'h0000_BEEF);
    chk("rb_word",   data_rdata, 32'h1122_BEEF);

    // Continuous data requests: bursts of four, one forced fetch in between
    cyc();
    data_req = 1'b1; data_addr = 14'h0004;
    pat = 12'b1111_0_1111_0_11;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      chk($sformatf("burst_gnt%0d", i),   data_gnt,    pat[11-i]);
      chk($sformatf("burst_stall%0d", i), fetch_stall, pat[11-i]);
      if (i > 0) chk($sformatf("burst_rv%0d", i), data_rvalid, pat[12-i]);
      cyc();
    end
    data_req = 1'b0;
    @(negedge clock);
    chk("burst_tail_rv", data_rvalid, 1);
    chk("burst_tail_gnt", data_gnt, 0);

    // Reset lands between a load grant and its completion edge
    cyc();
    data_req = 1'b1; data_addr = 14'h0004;
    @(negedge clock);
    chk("mid_gnt", data_gnt, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_gnt",   data_gnt,    0);
    chk("mid_rst_stall", fetch_stall, 1);
    cyc();
    chk("mid_rst_rvalid", data_rvalid, 0);
    chk("mid_rst_flush",  fetch_flush, 1);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("mid_rel_flush",  fetch_flush, 1);
    chk("mid_rel_rvalid", data_rvalid, 0);
    // A fresh counter yields a full burst of four before the forced fetch.
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clock);
      chk($sformatf("mid_burst%0d", i), data_gnt, (i < 4) ? 1 : 0);
    end
    #1;
    data_req = 1'b0;

    // Burst limit of one: data and fetch strictly alternate
    cyc();
    data_req1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk($sformatf("alt_gnt%0d", k),   data_gnt1,    (k % 2 == 0) ? 1 : 0);
      chk($sformatf("alt_flush%0d", k), fetch_flush1, (k % 2 == 1) ? 1 : 0);
      chk($sformatf("alt_rv%0d", k),    data_rvalid1, (k % 2 == 1) ? 1 : 0);
    end
    #1;
    data_req1 = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
